// File: rtl/switch_allocator_rr.sv
// switch_allocator_rr: per-input request FSMs with per-output round-robin arbitration driving crossbar selects
module switch_allocator_rr #(
  parameter int INPUTS     = 5,
  parameter int OUTPUTS    = 5,
  parameter int DEST_WIDTH = $clog2(OUTPUTS),
  parameter int SEL_WIDTH  = $clog2(INPUTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INPUTS-1:0]             req_valid,
  input  logic [INPUTS*DEST_WIDTH-1:0]  req_dest,
  input  logic [INPUTS-1:0]             pkt_release,
  output logic [INPUTS-1:0]             grant,
  output logic [INPUTS-1:0]             port_reserved,
  output logic [OUTPUTS*SEL_WIDTH-1:0]  route_select,
  output logic [OUTPUTS-1:0]            output_busy,
  output logic [INPUTS-1:0]             dest_error
);
  typedef enum logic [1:0] {IDLE, REQ, GRANT, HOLD} state_t;
  state_t                state [INPUTS];
  state_t                state_nx [INPUTS];
  logic [DEST_WIDTH-1:0] dest_q [INPUTS];
  logic [SEL_WIDTH-1:0]  rr_ptr [OUTPUTS];
  logic [SEL_WIDTH-1:0]  winner [OUTPUTS];
  logic [OUTPUTS-1:0]    won;
  logic [OUTPUTS-1:0]    freed;
  logic [INPUTS-1:0]     win;
  logic [INPUTS-1:0]     dest_ok;
  // an extra bit keeps the range check exact when OUTPUTS is a power of two
  always_comb begin
    dest_ok = '0;
    for (int i = 0; i < INPUTS; i++)
      dest_ok[i] = {1'b0, req_dest[i*DEST_WIDTH +: DEST_WIDTH]} < (DEST_WIDTH+1)'(OUTPUTS);
  end
  // cyclic search from each free output's pointer; withdrawing inputs never win
  always_comb begin
    won = '0;
    win = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      winner[o] = '0;
      for (int k = 0; k < INPUTS; k++) begin
        int p;
        logic [SEL_WIDTH-1:0] idx;
        p = int'(rr_ptr[o]) + k;
        p = (p >= INPUTS) ? p - INPUTS : p;
        idx = SEL_WIDTH'(p);
        if (!output_busy[o] && !won[o] && state[idx] == REQ && req_valid[idx] &&
            dest_q[idx] == DEST_WIDTH'(o)) begin
          won[o] = 1'b1;
          winner[o] = idx;
        end
      end
      if (won[o]) win[winner[o]] = 1'b1;
    end
  end
  // outputs whose owner's tail has gone through this cycle
  always_comb begin
    freed = '0;
    for (int i = 0; i < INPUTS; i++)
      if ((state[i] == GRANT || state[i] == HOLD) && pkt_release[i]) freed[dest_q[i]] = 1'b1;
  end
  // per-input next state and reservation status
  always_comb begin
    grant = '0;
    port_reserved = '0;
    for (int i = 0; i < INPUTS; i++) begin
      state_nx[i] = (state[i] == IDLE) ? ((req_valid[i] && dest_ok[i]) ? REQ : IDLE) :
                    (state[i] == REQ)  ? (!req_valid[i] ? IDLE : win[i] ? GRANT : REQ) :
                    pkt_release[i] ? IDLE : HOLD;
      grant[i] = state[i] == GRANT;
      port_reserved[i] = state[i] == GRANT || state[i] == HOLD;
    end
  end
  // state, destination latch, pointer, busy and select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < INPUTS; i++) begin
        state[i] <= IDLE;
        dest_q[i] <= '0;
      end
      for (int o = 0; o < OUTPUTS; o++) rr_ptr[o] <= '0;
      output_busy <= '0;
      route_select <= '0;
      dest_error <= '0;
    end else begin
      for (int i = 0; i < INPUTS; i++) begin
        state[i] <= state_nx[i];
        if (state[i] == IDLE && req_valid[i] && dest_ok[i]) dest_q[i] <= req_dest[i*DEST_WIDTH +: DEST_WIDTH];
        dest_error[i] <= state[i] == IDLE && req_valid[i] && !dest_ok[i];
      end
      for (int o = 0; o < OUTPUTS; o++) begin
        if (won[o]) begin
          rr_ptr[o] <= (winner[o] == SEL_WIDTH'(INPUTS-1)) ? '0 : winner[o] + 1'b1;
          output_busy[o] <= 1'b1;
          route_select[o*SEL_WIDTH +: SEL_WIDTH] <= winner[o];
        end else if (freed[o]) output_busy[o] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_switch_allocator_rr.sv
// tb_switch_allocator_rr: directed vectors with hand-computed expectations for the switch allocator
module tb_switch_allocator_rr;
  localparam int N = 5, M = 5, DW = 3, SW = 3;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, pkt_release, grant, port_reserved, dest_error;
  logic [N*DW-1:0] req_dest;
  logic [M*SW-1:0] route_select;
  logic [M-1:0] output_busy;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  switch_allocator_rr #(.INPUTS(N), .OUTPUTS(M)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dest(req_dest), .pkt_release(pkt_release),
    .grant(grant), .port_reserved(port_reserved), .route_select(route_select),
    .output_busy(output_busy), .dest_error(dest_error)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req(input int i, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_dest[i*DW +: DW] = d;
  endtask
  function automatic logic [31:0] rs(input int o);
    return 32'(route_select[o*SW +: SW]);
  endfunction
  initial begin
    rst = 1'b1; req_valid = '0; pkt_release = '0; req_dest = '0;
    tick(2);
    check("rst_grant", 32'(grant), 0);
    check("rst_reserved", 32'(port_reserved), 0);
    check("rst_busy", 32'(output_busy), 0);
    check("rst_route", 32'(route_select), 0);
    check("rst_dest_error", 32'(dest_error), 0);
    rst = 1'b0;
    req(1, 3);
    tick;
    check("s1_c1_grant", 32'(grant), 0);
    tick;
    check("s1_c2_grant", 32'(grant), 32'b00010);
    check("s1_c2_busy", 32'(output_busy), 32'b01000);
    check("s1_c2_route3", rs(3), 1);
    check("s1_c2_reserved", 32'(port_reserved), 32'b00010);
    req_valid[1] = 1'b0;
    tick;
    check("s1_c3_grant", 32'(grant), 0);
    check("s1_c3_reserved", 32'(port_reserved), 32'b00010);
    tick(2);
    pkt_release[1] = 1'b1;
    tick;
    pkt_release = '0;
    check("s1_c6_busy", 32'(output_busy), 0);
    check("s1_c6_reserved", 32'(port_reserved), 0);
    check("s1_c6_route_kept", rs(3), 1);
    req(0, 2); req(2, 2); req(4, 2);
    tick(2);
    check("s2_first_grant", 32'(grant), 32'b00001);
    check("s2_first_route", rs(2), 0);
    tick(3);
    pkt_release[0] = 1'b1;
    tick;
    pkt_release = '0;
    check("s2_rel0_busy", 32'(output_busy), 0);
    check("s2_rel0_no_regrant", 32'(grant), 0);
    tick;
    check("s2_second_grant", 32'(grant), 32'b00100);
    check("s2_second_route", rs(2), 2);
    req_valid[2] = 1'b0;
    tick(3);
    pkt_release[2] = 1'b1;
    tick;
    pkt_release = '0;
    tick;
    check("s2_third_grant", 32'(grant), 32'b10000);
    check("s2_third_route", rs(2), 4);
    req_valid[4] = 1'b0;
    tick(3);
    pkt_release[4] = 1'b1;
    tick;
    pkt_release = '0;
    tick;
    check("s2_fourth_grant", 32'(grant), 32'b00001);
    check("s2_fourth_route", rs(2), 0);
    req_valid[0] = 1'b0;
    pkt_release[0] = 1'b1;
    tick;
    pkt_release = '0;
    check("s2_end_busy", 32'(output_busy), 0);
    check("s2_end_reserved", 32'(port_reserved), 0);
    req(0, 1); req(3, 4);
    tick(2);
    check("s3_grant", 32'(grant), 32'b01001);
    check("s3_busy", 32'(output_busy), 32'b10010);
    check("s3_route1", rs(1), 0);
    check("s3_route4", rs(4), 3);
    req_valid = '0;
    tick;
    req(2, 1);
    tick(2);
    check("s4_blocked_grant", 32'(grant), 0);
    check("s4_blocked_reserved", 32'(port_reserved), 32'b01001);
    req_valid[2] = 1'b0;
    tick;
    check("s4_withdrawn_reserved", 32'(port_reserved), 32'b01001);
    pkt_release = 5'b01001;
    tick;
    pkt_release = '0;
    check("s4_freed_busy", 32'(output_busy), 0);
    tick;
    check("s4_no_late_grant", 32'(grant), 0);
    check("s4_no_late_busy", 32'(output_busy), 0);
    req(1, 7);
    tick;
    check("s4_dest_error", 32'(dest_error), 32'b00010);
    check("s4_bad_reserved", 32'(port_reserved), 0);
    req_valid[1] = 1'b0;
    tick;
    check("s4_dest_error_pulse", 32'(dest_error), 0);
    check("s4_bad_busy", 32'(output_busy), 0);
    req(0, 0);
    tick;
    req(1, 0);
    tick;
    check("s5_hold_grant", 32'(grant), 32'b00001);
    req_valid[0] = 1'b0;
    tick(2);
    req_dest[1*DW +: DW] = 3'd3;
    tick(6);
    check("s5_dest_change_ignored", 32'(output_busy), 32'b00001);
    check("s5_waiting_grant", 32'(grant), 0);
    req(3, 2);
    pkt_release[0] = 1'b1;
    tick;
    pkt_release = '0;
    check("s5_c11_busy", 32'(output_busy), 0);
    tick;
    check("s5_c12_grant", 32'(grant), 32'b01010);
    check("s5_c12_busy", 32'(output_busy), 32'b00101);
    check("s5_c12_route0", rs(0), 1);
    check("s5_c12_route2", rs(2), 3);
    req_valid = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("s6_grant", 32'(grant), 0);
    check("s6_reserved", 32'(port_reserved), 0);
    check("s6_busy", 32'(output_busy), 0);
    check("s6_route", 32'(route_select), 0);
    req(1, 0); req(4, 0);
    tick(2);
    check("s6_ptr_grant", 32'(grant), 32'b00010);
    check("s6_ptr_route0", rs(0), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
